// File: rtl/zero_run_scan_arbiter.sv
// Round-robin arbiter that takes one word from one channel and counts its non-overlapping zero runs.
// The word is scanned one bit per cycle, LSB first, and the count is held until the consumer takes it.
module zero_run_scan_arbiter #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NCH-1:0]            req_valid,
   input  logic [NCH*WORD_W-1:0]     req_data,
   output logic [NCH-1:0]            req_ready,
   input  logic [2:0]                run_len,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NCH)-1:0]    rsp_ch,
   output logic [CNT_W-1:0]          rsp_count,
   output logic                      busy
);

   localparam int unsigned CH_W  = $clog2(NCH);
   localparam int unsigned BIT_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_any;
   logic              accept;
   logic [WORD_W-1:0] data_q;
   logic [BIT_W-1:0]  bit_cnt;
   logic [2:0]        run_q;
   logic [2:0]        zrun;
   logic [2:0]        run_eff;
   int unsigned       idx;

   // First valid channel at or after rr_ptr, wrapping.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         idx = (int'(rr_ptr) + k) % NCH;
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = CH_W'(idx);
         end
      end
   end

   assign accept  = (state == IDLE) && grant_any;
   assign run_eff = (run_len == 3'd0) ? 3'd1 : run_len;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // SCAN lingers one cycle after the last bit so the final count settles before RESP.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = SCAN;
         SCAN:    if (bit_cnt == BIT_W'(WORD_W)) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (accept && !reset) req_ready[grant_idx] = 1'b1;
      busy      = (state != IDLE);
      rsp_valid = (state == RESP);
   end

   // Job capture and bit-serial zero-run detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         data_q    <= '0;
         bit_cnt   <= '0;
         run_q     <= '0;
         zrun      <= '0;
         rsp_ch    <= '0;
         rsp_count <= '0;
      end else if (accept) begin
         data_q    <= req_data[grant_idx*WORD_W +: WORD_W];
         rsp_ch    <= grant_idx;
         run_q     <= run_eff;
         rr_ptr    <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
         zrun      <= '0;
         rsp_count <= '0;
         bit_cnt   <= '0;
      end else if (state == SCAN && bit_cnt != BIT_W'(WORD_W)) begin
         bit_cnt <= bit_cnt + BIT_W'(1);
         data_q  <= data_q >> 1;
         if (data_q[0]) begin
            zrun <= '0;
         end else if (zrun + 3'd1 == run_q) begin
            zrun      <= '0;
            rsp_count <= rsp_count + CNT_W'(1);
         end else begin
            zrun <= zrun + 3'd1;
         end
      end
   end

endmodule
